// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID read checker.
package sysid_checker_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERR_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_LAT_ID,
    ST_CMP_ID,
    ST_REQ_TS,
    ST_LAT_TS,
    ST_CMP_TS,
    ST_FIN
  } state_e;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_ID      = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TS      = 2'd2;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_read_port.sv
// Single Avalon-MM read: holds the strobe through waitrequest, waits out the
// fixed read latency and captures readdata. Optional stall timeout is built
// when SYSID_CHECKER_TIMEOUT_EN is defined.
module sysid_read_port
  import sysid_checker_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              addr,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              accept_c,
  output logic              capture_c,
  output logic              timeout_c,
  output logic [DATA_W-1:0] data
);

  // Reject configurations the latency counter and timeout cannot represent
  if (READ_LATENCY > 3 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("sysid_read_port: READ_LATENCY must be 0..3 and TIMEOUT_CYCLES at least 1");
  end

  logic [1:0] lat_cnt_q;

  // Strobe up and slave not stalling: the read is taken this cycle
  assign accept_c  = avm_read & ~avm_waitrequest;
  // Zero latency samples on the accept edge, otherwise on the last latency cycle
  assign capture_c = (READ_LATENCY == 0) ? accept_c : (lat_cnt_q == 2'd1);

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES
  assign timeout_c = avm_read & avm_waitrequest &
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled cycles of the current read
  always_ff @(posedge clock) begin
    if (reset || !avm_read || !avm_waitrequest || timeout_c) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Bus strobe, latency countdown and data capture
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      lat_cnt_q   <= 2'd0;
      data        <= '0;
    end else begin
      if (req) begin
        avm_read    <= 1'b1;
        avm_address <= addr;
      end else if (accept_c || timeout_c) begin
        avm_read <= 1'b0;
      end
      if (accept_c && READ_LATENCY != 0) begin
        lat_cnt_q <= 2'(READ_LATENCY);
      end else if (lat_cnt_q != 2'd0) begin
        lat_cnt_q <= lat_cnt_q - 2'd1;
      end
      if (capture_c) begin
        data <= avm_readdata;
      end
    end
  end

endmodule

// File: rtl/sysid_read_checker.sv
// Reads the system-ID word and timestamp after a start pulse and reports
// whether both match the build-time values. Optional per-read stall timeout
// is enabled by defining SYSID_CHECKER_TIMEOUT_EN.
module sysid_read_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1490220311,
  parameter int unsigned       READ_LATENCY       = 0,
  parameter int unsigned       TIMEOUT_CYCLES     = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] timestamp_value,
  output logic [ERR_W-1:0]  error_code
);

  state_e            state_q, state_d;
  logic              req_c, req_addr_c;
  logic              accept_c, capture_c, timeout_c;
  logic [DATA_W-1:0] port_data, id_d, ts_d;
  logic [ERR_W-1:0]  err_d;
  logic              pass_d;

  sysid_read_port #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_port (
    .clock           (clock),
    .reset           (reset),
    .req             (req_c),
    .addr            (req_addr_c),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .accept_c        (accept_c),
    .capture_c       (capture_c),
    .timeout_c       (timeout_c),
    .data            (port_data)
  );

  // Sequence ID read then timestamp read, compare, and build the next results
  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    req_addr_c = ADDR_ID;
    id_d       = id_value;
    ts_d       = timestamp_value;
    err_d      = error_code;
    pass_d     = pass;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_REQ_ID;
          req_c      = 1'b1;
          req_addr_c = ADDR_ID;
          id_d       = '0;
          ts_d       = '0;
          err_d      = ERR_NONE;
          pass_d     = 1'b0;
        end
      end
      ST_REQ_ID: begin
        if (timeout_c) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_FIN;
        end else if (capture_c) begin
          state_d = ST_CMP_ID;
        end else if (accept_c) begin
          state_d = ST_LAT_ID;
        end
      end
      ST_LAT_ID: begin
        if (capture_c) state_d = ST_CMP_ID;
      end
      ST_CMP_ID: begin
        id_d = port_data;
        if (port_data != EXPECTED_ID) begin
          err_d   = ERR_ID;
          state_d = ST_FIN;
        end else begin
          state_d    = ST_REQ_TS;
          req_c      = 1'b1;
          req_addr_c = ADDR_TS;
        end
      end
      ST_REQ_TS: begin
        if (timeout_c) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_FIN;
        end else if (capture_c) begin
          state_d = ST_CMP_TS;
        end else if (accept_c) begin
          state_d = ST_LAT_TS;
        end
      end
      ST_LAT_TS: begin
        if (capture_c) state_d = ST_CMP_TS;
      end
      ST_CMP_TS: begin
        ts_d = port_data;
        if (port_data != EXPECTED_TIMESTAMP) err_d = ERR_TS;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_FIN && state_q != ST_FIN) pass_d = (err_d == ERR_NONE);
  end

  // State and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_code      <= ERR_NONE;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      state_q         <= state_d;
      busy            <= (state_d != ST_IDLE);
      done            <= (state_d == ST_FIN);
      pass            <= pass_d;
      error_code      <= err_d;
      id_value        <= id_d;
      timestamp_value <= ts_d;
    end
  end

endmodule

// File: tb/tb_sysid_read_checker.sv
// Bench for sysid_read_checker: instance a has zero read latency, instance b
// has READ_LATENCY=2 and TIMEOUT_CYCLES=8. Timeout expectations follow
// SYSID_CHECKER_TIMEOUT_EN.
module tb_sysid_read_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1490220311;
  localparam int          LAT_B  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        rd_a, ad_a, wr_a, busy_a, done_a, pass_a;
  logic        rd_b, ad_b, wr_b, busy_b, done_b, pass_b;
  logic [31:0] rdata_a, idv_a, tsv_a, rdata_b, idv_b, tsv_b;
  logic [1:0]  err_a, err_b;

  // Slave content and stall profile per instance (0 = a, 1 = b)
  logic [31:0] word_id [2];
  logic [31:0] word_ts [2];
  int          sid [2];
  int          sts [2];
  logic        stuck [2];
  int          held [2];
  logic        ad1_b, ad2_b;

  int n_checks = 0;
  int n_fail   = 0;
  int tsr [2];
  int viol [2];
  logic pr [2];
  logic pw [2];
  logic pa [2];
  bit   tmo_test;

  int          got_done, n_done;
  logic        got_busy_after, got_pass;
  logic [1:0]  got_err;
  logic [31:0] got_id, got_ts;

  always #5 clock = ~clock;

  sysid_read_checker u_dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .avm_address(ad_a), .avm_read(rd_a), .avm_waitrequest(wr_a), .avm_readdata(rdata_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .id_value(idv_a), .timestamp_value(tsv_a), .error_code(err_a)
  );

  sysid_read_checker #(.READ_LATENCY(LAT_B), .TIMEOUT_CYCLES(8)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .avm_address(ad_b), .avm_read(rd_b), .avm_waitrequest(wr_b), .avm_readdata(rdata_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .id_value(idv_b), .timestamp_value(tsv_b), .error_code(err_b)
  );

  // Slave: stall each read for its configured count, then answer
  assign wr_a = stuck[0] | (rd_a && (held[0] < (ad_a ? sts[0] : sid[0])));
  assign wr_b = stuck[1] | (rd_b && (held[1] < (ad_b ? sts[1] : sid[1])));
  assign rdata_a = ad_a ? word_ts[0] : word_id[0];
  assign rdata_b = ad2_b ? word_ts[1] : word_id[1];

  always @(posedge clock) begin
    held[0] <= (rd_a && wr_a) ? held[0] + 1 : 0;
    held[1] <= (rd_b && wr_b) ? held[1] + 1 : 0;
    ad1_b   <= ad_b;
    ad2_b   <= ad1_b;
  end

  // Bus monitor: strobe/address held across stalls; count timestamp reads
  always @(negedge clock) begin
    if (reset) begin
      pr[0] = 1'b0; pr[1] = 1'b0;
    end else begin
      if (pr[0] && pw[0] && !(rd_a && ad_a == pa[0])) viol[0]++;
      if (!tmo_test && pr[1] && pw[1] && !(rd_b && ad_b == pa[1])) viol[1]++;
      if (rd_a && !wr_a && ad_a) tsr[0]++;
      if (rd_b && !wr_b && ad_b) tsr[1]++;
      pr[0] = rd_a; pw[0] = wr_a; pa[0] = ad_a;
      pr[1] = rd_b; pw[1] = wr_b; pa[1] = ad_b;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 1) start_b = v; else start_a = v;
  endtask

  // One start pulse at cycle 0, optional extra start at cycle extra_start
  task automatic run_txn(input int inst, input logic [31:0] id, input logic [31:0] ts,
                         input int s_id, input int s_ts, input int extra_start);
    logic d;
    word_id[inst] = id; word_ts[inst] = ts; sid[inst] = s_id; sts[inst] = s_ts;
    @(negedge clock);
    tsr[inst] = 0; viol[inst] = 0;
    set_start(inst, 1'b1);
    got_done = -1; n_done = 0; got_busy_after = 1'bx;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      set_start(inst, c == extra_start);
      d = (inst == 1) ? done_b : done_a;
      if (d) begin
        n_done++;
        if (got_done < 0) begin
          got_done = c;
          got_err  = (inst == 1) ? err_b : err_a;
          got_pass = (inst == 1) ? pass_b : pass_a;
          got_id   = (inst == 1) ? idv_b : idv_a;
          got_ts   = (inst == 1) ? tsv_b : tsv_a;
        end
      end
      if (got_done >= 0 && c == got_done + 1) got_busy_after = (inst == 1) ? busy_b : busy_a;
      if (got_done >= 0 && c >= got_done + 10) break;
    end
    set_start(inst, 1'b0);
  endtask

  task automatic compare(input string tag, input int inst, input int e_done, input int e_err,
                         input int e_pass, input logic [31:0] e_id, input logic [31:0] e_ts,
                         input int e_tsr);
    check({tag, ".done_cycle"}, 32'(got_done), 32'(e_done));
    check({tag, ".error_code"}, 32'(got_err), 32'(e_err));
    check({tag, ".pass"}, 32'(got_pass), 32'(e_pass));
    check({tag, ".id_value"}, got_id, e_id);
    check({tag, ".timestamp_value"}, got_ts, e_ts);
    check({tag, ".ts_reads"}, 32'(tsr[inst]), 32'(e_tsr));
    check({tag, ".stall_hold_violations"}, 32'(viol[inst]), 32'd0);
    check({tag, ".done_pulses"}, 32'(n_done), 32'd1);
    check({tag, ".busy_after_done"}, 32'(got_busy_after), 32'd0);
  endtask

  // Reference: each read costs its stalls, the accept cycle, the latency and a
  // compare cycle; done follows. A failed ID skips the timestamp read.
  task automatic model_check(input string tag, input int inst, input logic [31:0] id,
                             input logic [31:0] ts, input int s_id, input int s_ts);
    int lat, err, dcyc;
    lat  = (inst == 1) ? LAT_B : 0;
    err  = (id != EXP_ID) ? 1 : ((ts != EXP_TS) ? 2 : 0);
    dcyc = 1 + (s_id + 1 + lat + 1) + ((err == 1) ? 0 : (s_ts + 1 + lat + 1));
    compare(tag, inst, dcyc, err, (err == 0) ? 1 : 0, id, (err == 1) ? 32'd0 : ts,
            (err == 1) ? 0 : 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    int          inst;
    logic [31:0] id;
    logic [31:0] ts;
    int          s_id;
    int          s_ts;
    int          e_done;
    int          e_err;
    int          e_pass;
    logic [31:0] e_id;
    logic [31:0] e_ts;
    int          e_tsr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cnt, dn;
    vecs[0] = '{0, EXP_ID, EXP_TS, 0, 0, 5, 0, 1, EXP_ID, EXP_TS, 1};
    vecs[1] = '{0, 32'd5, EXP_TS, 0, 0, 3, 1, 0, 32'd5, 32'd0, 0};
    vecs[2] = '{0, EXP_ID, 32'd1490220310, 0, 0, 5, 2, 0, EXP_ID, 32'd1490220310, 1};
    vecs[3] = '{1, EXP_ID, EXP_TS, 2, 2, 13, 0, 1, EXP_ID, EXP_TS, 1};
    vecs[4] = '{0, 32'h8000_0000, EXP_TS, 0, 0, 3, 1, 0, 32'h8000_0000, 32'd0, 0};
    vecs[5] = '{1, EXP_ID, 32'hFFFF_FFFF, 0, 0, 9, 2, 0, EXP_ID, 32'hFFFF_FFFF, 1};
    vecs[6] = '{0, EXP_ID, EXP_TS, 1, 3, 9, 0, 1, EXP_ID, EXP_TS, 1};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; tmo_test = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stuck[i] = 1'b0; sid[i] = 0; sts[i] = 0; tsr[i] = 0; viol[i] = 0;
      word_id[i] = EXP_ID; word_ts[i] = EXP_TS;
    end
    repeat (3) @(negedge clock);

    // Reset values
    check("reset.busy", 32'({busy_a, busy_b}), 32'd0);
    check("reset.done", 32'({done_a, done_b}), 32'd0);
    check("reset.pass", 32'({pass_a, pass_b}), 32'd0);
    check("reset.error_code", 32'({err_a, err_b}), 32'd0);
    check("reset.id_value", idv_a | idv_b, 32'd0);
    check("reset.timestamp_value", tsv_a | tsv_b, 32'd0);
    check("reset.avm_read", 32'({rd_a, rd_b}), 32'd0);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].inst, vecs[i].id, vecs[i].ts, vecs[i].s_id, vecs[i].s_ts, -1);
      compare($sformatf("vec%0d", i), vecs[i].inst, vecs[i].e_done, vecs[i].e_err,
              vecs[i].e_pass, vecs[i].e_id, vecs[i].e_ts, vecs[i].e_tsr);
    end

    // Randomized transactions against the reference
    for (int i = 0; i < 24; i++) begin
      int inst, s1, s2;
      logic [31:0] id, ts;
      inst = int'($urandom_range(0, 1));
      id   = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      ts   = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      s1   = int'($urandom_range(0, 3));
      s2   = int'($urandom_range(0, 3));
      run_txn(inst, id, ts, s1, s2, -1);
      model_check($sformatf("rand%0d", i), inst, id, ts, s1, s2);
    end

    // Start while busy, and start in the done cycle, are both ignored
    run_txn(0, EXP_ID, EXP_TS, 0, 0, 2);
    compare("start_mid", 0, 5, 0, 1, EXP_ID, EXP_TS, 1);
    run_txn(0, EXP_ID, EXP_TS, 0, 0, 5);
    compare("start_at_done", 0, 5, 0, 1, EXP_ID, EXP_TS, 1);

    // Permanently stalled slave
    tmo_test = 1'b1;
    stuck[1] = 1'b1;
    @(negedge clock);
    start_b = 1'b1;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    cnt = 0; got_done = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      start_b = 1'b0;
      if (rd_b) cnt++;
      if (done_b && got_done < 0) begin
        got_done = c; got_err = err_b; got_pass = pass_b;
      end
    end
    check("timeout.read_cycles", 32'(cnt), 32'd8);
    check("timeout.done_cycle", 32'(got_done), 32'd9);
    check("timeout.error_code", 32'(got_err), 32'd3);
    check("timeout.pass", 32'(got_pass), 32'd0);
`else
    cnt = 0; dn = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      start_b = 1'b0;
      if (!busy_b || !rd_b) cnt++;
      if (done_b) dn++;
    end
    check("hang.busy_or_read_low", 32'(cnt), 32'd0);
    check("hang.done_pulses", 32'(dn), 32'd0);
`endif
    stuck[1] = 1'b0;
    do_reset();
    tmo_test = 1'b0;

    // Reset during LAT_ID aborts without a done pulse
    run_txn(1, EXP_ID, EXP_TS, 0, 0, -1);
    compare("pre_abort", 1, 9, 0, 1, EXP_ID, EXP_TS, 1);
    @(negedge clock);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort.busy", 32'(busy_b), 32'd0);
    check("abort.pass", 32'(pass_b), 32'd0);
    check("abort.error_code", 32'(err_b), 32'd0);
    check("abort.id_value", idv_b, 32'd0);
    check("abort.timestamp_value", tsv_b, 32'd0);
    check("abort.avm_read", 32'(rd_b), 32'd0);
    reset = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clock);
      if (done_b) dn++;
    end
    check("abort.done_pulses", 32'(dn), 32'd0);
    run_txn(1, EXP_ID, EXP_TS, 0, 0, -1);
    compare("post_abort", 1, 9, 0, 1, EXP_ID, EXP_TS, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
